// File: rtl/jesd204b_rx_lane_sync.sv
// JESD204B subclass-1 per-lane receiver: code group sync, ILAS check/capture,
// then aligned user data with start-of-multiframe marking and error monitoring.
module jesd204b_rx_lane_sync #(
    parameter int F_OCTETS   = 1,
    parameter int K_FRAMES   = 32,
    parameter int CGS_WORDS  = 4,
    parameter int ILAS_MF    = 4,
    parameter int ERR_THRESH = 2
) (
    input  logic         i_rxusrclk2,
    input  logic         i_rst_n,
    input  logic         i_link_en,
    input  logic         i_resync_req,
    input  logic         i_byte_aligned,
    input  logic [31:0]  i_rxdata,
    input  logic [3:0]   i_charisk,
    input  logic [3:0]   i_disperr,
    input  logic [3:0]   i_notintable,
    output logic         o_nsync,
    output logic [1:0]   o_state,
    output logic         o_ilas_done,
    output logic [111:0] o_ilas_cfg,
    output logic [31:0]  o_data,
    output logic         o_data_valid,
    output logic         o_somf,
    output logic [15:0]  o_err_cnt
);
    // state | meaning
    // 0     | SYNC_REQ: nSYNC low, counting consecutive good /K/ words
    // 1     | CGS_DONE: nSYNC high, waiting for the first /R/ of the ILAS
    // 2     | ILAS:     checking multiframe markers, capturing config octets
    // 3     | DATA:     delivering user data, monitoring octet errors
    localparam logic [1:0] S_SYNC_REQ = 2'd0;
    localparam logic [1:0] S_CGS_DONE = 2'd1;
    localparam logic [1:0] S_ILAS     = 2'd2;
    localparam logic [1:0] S_DATA     = 2'd3;

    localparam logic [7:0] C_K = 8'hBC;
    localparam logic [7:0] C_R = 8'h1C;
    localparam logic [7:0] C_A = 8'h7C;
    localparam logic [7:0] C_Q = 8'h9C;

    localparam int MF_WORDS = F_OCTETS * K_FRAMES / 4;
    localparam int WC_W     = $clog2(MF_WORDS);
    localparam int CG_W     = $clog2(CGS_WORDS + 1);
    localparam int MF_W     = $clog2(ILAS_MF + 1);

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MF_WORDS - 1);
    localparam logic [CG_W-1:0] CG_LAST = CG_W'(CGS_WORDS - 1);
    localparam logic [MF_W-1:0] MF_LAST = MF_W'(ILAS_MF - 1);
    localparam logic [7:0]      MFE_TH  = 8'(ERR_THRESH);

    logic [1:0]      r_state;
    logic [CG_W-1:0] r_cgs_cnt;
    logic [WC_W-1:0] r_wcnt;
    logic [MF_W-1:0] r_mf_idx;
    logic [7:0]      r_mf_err;
    logic            r_prev_k;
    logic [111:0]    r_ilas_cfg;
    logic            r_ilas_done;
    logic [31:0]     r_data;
    logic            r_data_valid;
    logic            r_somf;
    logic [15:0]     r_err_cnt;

    logic [3:0]  w_oct_err;
    logic        w_any_err;
    logic [2:0]  w_err_n;
    logic        w_good_k;
    logic        w_oct0_r;
    logic        w_oct1_q;
    logic        w_oct3_a;
    logic        w_wc_first;
    logic        w_wc_last;
    logic        w_ilas_fail;
    logic [7:0]  w_mf_err_nxt;
    logic        w_data_fail;
    logic [16:0] w_err_sum;

    assign w_oct_err  = i_disperr | i_notintable;
    assign w_any_err  = |w_oct_err;
    assign w_err_n    = 3'(w_oct_err[0]) + 3'(w_oct_err[1]) + 3'(w_oct_err[2]) + 3'(w_oct_err[3]);
    assign w_good_k   = (i_rxdata == {4{C_K}}) && (i_charisk == 4'hF) && !w_any_err && i_byte_aligned;
    assign w_oct0_r   = (i_rxdata[7:0]   == C_R) && i_charisk[0];
    assign w_oct1_q   = (i_rxdata[15:8]  == C_Q) && i_charisk[1];
    assign w_oct3_a   = (i_rxdata[31:24] == C_A) && i_charisk[3];
    assign w_wc_first = (r_wcnt == '0);
    assign w_wc_last  = (r_wcnt == WC_LAST);

    assign w_ilas_fail = w_any_err
                       || (w_wc_first && !w_oct0_r)
                       || (w_wc_last && !w_oct3_a)
                       || ((r_mf_idx == MF_W'(1)) && w_wc_first && !w_oct1_q);

    // Per-multiframe error tally restarts on the word at wcnt 0.
    assign w_mf_err_nxt = (w_wc_first ? 8'd0 : r_mf_err) + {5'd0, w_err_n};
    assign w_data_fail  = (w_mf_err_nxt >= MFE_TH) || (w_good_k && r_prev_k);
    assign w_err_sum    = {1'b0, r_err_cnt} + {14'd0, w_err_n};

    always_ff @(posedge i_rxusrclk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_SYNC_REQ;
            r_cgs_cnt    <= '0;
            r_wcnt       <= '0;
            r_mf_idx     <= '0;
            r_mf_err     <= '0;
            r_prev_k     <= 1'b0;
            r_ilas_cfg   <= '0;
            r_ilas_done  <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_somf       <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (r_state == S_DATA)
                r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

            if (!i_link_en || i_resync_req) begin
                r_state      <= S_SYNC_REQ;
                r_cgs_cnt    <= '0;
                r_data_valid <= 1'b0;
                r_somf       <= 1'b0;
                r_ilas_done  <= 1'b0;
                if (r_state == S_ILAS)
                    r_ilas_cfg <= '0;
            end else begin
                case (r_state)
                    S_SYNC_REQ: begin
                        if (!w_good_k)
                            r_cgs_cnt <= '0;
                        else if (r_cgs_cnt == CG_LAST) begin
                            r_cgs_cnt <= '0;
                            r_state   <= S_CGS_DONE;
                        end else
                            r_cgs_cnt <= r_cgs_cnt + CG_W'(1);
                    end
                    S_CGS_DONE: begin
                        if (!w_good_k) begin
                            if (w_oct0_r && !w_any_err) begin
                                r_state  <= S_ILAS;
                                r_wcnt   <= WC_W'(1);
                                r_mf_idx <= '0;
                            end else
                                r_state <= S_SYNC_REQ;
                        end
                    end
                    S_ILAS: begin
                        if (w_ilas_fail) begin
                            r_state    <= S_SYNC_REQ;
                            r_cgs_cnt  <= '0;
                            r_ilas_cfg <= '0;
                        end else begin
                            // Multiframe 1 carries the link configuration.
                            if (r_mf_idx == MF_W'(1)) begin
                                if (w_wc_first)
                                    r_ilas_cfg[15:0] <= i_rxdata[31:16];
                                for (int w = 1; w <= 3; w++)
                                    if (r_wcnt == WC_W'(w))
                                        r_ilas_cfg[32*w-16 +: 32] <= i_rxdata;
                            end
                            if (w_wc_last) begin
                                r_wcnt <= '0;
                                if (r_mf_idx == MF_LAST) begin
                                    r_state     <= S_DATA;
                                    r_ilas_done <= 1'b1;
                                    r_mf_err    <= '0;
                                    r_prev_k    <= 1'b0;
                                end else
                                    r_mf_idx <= r_mf_idx + MF_W'(1);
                            end else
                                r_wcnt <= r_wcnt + WC_W'(1);
                        end
                    end
                    default: begin
                        r_mf_err <= w_mf_err_nxt;
                        r_prev_k <= w_good_k;
                        r_wcnt   <= w_wc_last ? '0 : r_wcnt + WC_W'(1);
                        if (w_data_fail) begin
                            r_state      <= S_SYNC_REQ;
                            r_data_valid <= 1'b0;
                            r_somf       <= 1'b0;
                            r_ilas_done  <= 1'b0;
                        end else begin
                            r_data       <= i_rxdata;
                            r_data_valid <= 1'b1;
                            r_somf       <= w_wc_first;
                        end
                    end
                endcase
            end
        end
    end

    assign o_nsync      = (r_state != S_SYNC_REQ);
    assign o_state      = r_state;
    assign o_ilas_done  = r_ilas_done;
    assign o_ilas_cfg   = r_ilas_cfg;
    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_somf       = r_somf;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: doc/jesd204b_rx_lane_sync.md
Name: jesd204b_rx_lane_sync

Overview:
- Per-lane JESD204B subclass-1 link-layer receiver.
- Sits directly downstream of the GT RX datapath. It consumes 32-bit 8b10b-decoded user data plus the per-octet K/error flags on the rxusrclk2 domain.
- Performs code group synchronisation (CGS) and drives the lane's nSYNC request.
- Checks and parses the ILAS, captures the 14 link-configuration octets, then delivers aligned user data with start-of-multiframe marking and error monitoring.

Parameters:
- F_OCTETS, 1, octets per frame.
- K_FRAMES, 32, frames per multiframe. F_OCTETS*K_FRAMES must be a multiple of 4 in the range 16..1024; MF_WORDS = F_OCTETS*K_FRAMES/4.
- CGS_WORDS, 4, consecutive all-/K/ words required to finish CGS.
- ILAS_MF, 4, number of ILAS multiframes.
- ERR_THRESH, 2, disparity/not-in-table errors within one multiframe that force resync.

Ports:
- i_rxusrclk2  in  1  sole clock; user-side clock of the GT.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_link_en  in  1  0 holds the lane in SYNC_REQ.
- i_resync_req  in  1  single-cycle request to restart CGS.
- i_byte_aligned  in  1  GT comma-alignment status.
- i_rxdata  in  32  decoded octets; [7:0] is the earliest octet.
- i_charisk  in  4  K flag per octet.
- i_disperr  in  4  disparity error per octet.
- i_notintable  in  4  not-in-table error per octet.
- o_nsync  out  1  JESD nSYNC, active low.
- o_state  out  2  0 SYNC_REQ, 1 CGS_DONE, 2 ILAS, 3 DATA.
- o_ilas_done  out  1  ILAS verified (level).
- o_ilas_cfg  out  112  config octets 0..13; octet n is at [8n+7:8n].
- o_data  out  32  user data.
- o_data_valid  out  1  o_data is valid.
- o_somf  out  1  o_data word is the first word of a multiframe.
- o_err_cnt  out  16  saturating count of octet errors seen in DATA.

Behaviour:
- Reset values: every output is 0, except o_nsync = 0 (sync requested) and o_state = SYNC_REQ.
- Code constants: /K/ = 0xBC, /R/ = 0x1C, /A/ = 0x7C, /Q/ = 0x9C. Each is valid only when its charisk bit is 1.
- A "good K word" is all four octets /K/, no disperr, no notintable, and i_byte_aligned = 1.

SYNC_REQ:
- o_nsync = 0.
- Counter cgs_cnt increments on each good K word and clears on any other word.
- When cgs_cnt reaches CGS_WORDS, go to CGS_DONE. o_nsync goes to 1 on the cycle after the CGS_WORDS-th good word.

CGS_DONE:
- Good K words are ignored.
- First non-/K/ word with octet0 = /R/: go to ILAS. This word is ILAS word 0; mf_idx = 0, wcnt = 1.
- First non-/K/ word with octet0 ≠ /R/, or any octet error: go to SYNC_REQ.

ILAS:
- wcnt counts 0..MF_WORDS-1 and wraps; mf_idx increments on wrap.
- Word 0 of each multiframe: octet0 must be /R/.
- Last word of each multiframe: octet3 must be /A/.
- Multiframe 1 only:
  - word 0 octet1 must be /Q/;
  - capture cfg octets 0..1 from word 0 octets 2..3;
  - capture cfg octets 2..13 from words 1..3 (octets in order).
- Any check failure or any octet error: go to SYNC_REQ, clear cgs_cnt, clear o_ilas_cfg.
- After the last word of multiframe ILAS_MF-1: o_ilas_done = 1 and go to DATA.
- The first DATA input word is the next input word, at wcnt = 0.

DATA:
- Output pipeline, 1 cycle latency: o_data = i_rxdata of the previous cycle and o_data_valid = 1.
- o_somf = 1 alongside the output word whose input had wcnt = 0.
- Each cycle, o_err_cnt adds the popcount of (disperr | notintable), saturating at 0xFFFF.
- A per-multiframe error count (mf_err) resets at wcnt = 0. If it reaches ≥ ERR_THRESH, go to SYNC_REQ.
- Two consecutive good K words also go to SYNC_REQ (link restart by the transmitter).
- o_err_cnt clears only on reset.

Exit from DATA or ILAS to SYNC_REQ:
- o_data_valid, o_somf and o_ilas_done drop and o_nsync goes to 0 on the next cycle.
- o_data holds its last value.

Priority (highest first): reset, ~i_link_en, i_resync_req, error/check failure, normal transition.
- A simultaneous resync and state advance resolves to SYNC_REQ.
- While i_link_en = 0, cgs_cnt is held at 0.

Test Plan:
- After reset, send 3 good K words (0xBCBCBCBC, charisk F) -> o_nsync stays 0. The 4th word -> o_nsync = 1 and o_state = 1 on the next cycle.
- Good K words with one mid-stream word 0x00BCBCBC -> cgs_cnt clears and o_nsync = 1 only after 4 further good words. Repeat with i_byte_aligned = 0 -> no progress.
- F=1, K=32 (MF_WORDS = 8): legal 4-multiframe ILAS with cfg octets 0x01..0x0E -> o_ilas_cfg = 0x0E0D...0201 and o_ilas_done = 1. The first data word 0xDEADBEEF appears with o_data_valid = 1 and o_somf = 1 one cycle after input, and o_somf repeats every 8 words.
- ILAS multiframe 1 last octet 0x7D instead of /A/ -> o_state = 0 and o_nsync = 0 next cycle, o_ilas_cfg = 0. Multiframe 1 octet1 not /Q/ -> same response.
- In DATA: one disperr bit -> o_err_cnt = 1 and the lane stays in DATA. Two errors within one multiframe -> SYNC_REQ. Errors split across a wcnt = 0 boundary -> the lane stays in DATA and o_err_cnt = 2.
- In DATA, drop i_link_en for 1 cycle -> o_data_valid = 0 and o_nsync = 0. Assert i_rst_n = 0 mid-ILAS (asynchronous, no clock edge) -> all outputs reset immediately.
